// File: rtl/cnn_buf_pkg.sv
// Shared types and sizes for the CNN scratch-buffer sequencer.
// Optional almost-full output is enabled with BUF_CTRL_ALMOST_FULL_EN (see buffer_ctrl).
package cnn_buf_pkg;

  localparam int BUF_DEPTH = 16;
  localparam int BUF_AW    = 4;
  localparam int BUF_DW    = 8;

  typedef logic signed [BUF_DW-1:0] buf_word_t;
  typedef logic        [BUF_AW-1:0] buf_addr_t;

  // RUN is normal streaming; FLUSH marks the cycle right after a clear.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } buf_ctrl_st_e;

endpackage

// File: rtl/buf_ctrl_outstage.sv
// Two-slot output stage for buffer_ctrl. Slot0 is the head shown on m_data,
// slot1 is a skid slot that absorbs the word already in flight from the
// buffer when the consumer stalls. Also tracks the one-cycle read in flight
// and reports how many slots are free after this cycle's pop.
module buf_ctrl_outstage
  import cnn_buf_pkg::*;
#(
  parameter int DW = BUF_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 issue,
  input  logic signed [DW-1:0] buf_data,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic signed [DW-1:0] m_data,
  output logic [1:0]           free_slots,
  output logic                 rd_inflight
);

  logic                 slot0Valid_q, slot0Valid_d;
  logic                 slot1Valid_q, slot1Valid_d;
  logic signed [DW-1:0] slot0Data_q,  slot0Data_d;
  logic signed [DW-1:0] slot1Data_q,  slot1Data_d;
  logic                 inflight_q,   inflight_d;
  logic                 pop;
  logic [1:0]           freeSlots;

  // Pop first, then drop the arriving read word into the first empty slot;
  // free slots are counted between those two steps so the issue logic sees
  // room made by a pop but not yet taken by the capture.
  always_comb begin
    pop          = slot0Valid_q & m_ready;
    slot0Valid_d = slot0Valid_q;
    slot0Data_d  = slot0Data_q;
    slot1Valid_d = slot1Valid_q;
    slot1Data_d  = slot1Data_q;
    inflight_d   = issue;

    if (pop) begin
      slot0Valid_d = slot1Valid_q;
      slot0Data_d  = slot1Data_q;
      slot1Valid_d = 1'b0;
    end

    freeSlots = {1'b0, ~slot0Valid_d} + {1'b0, ~slot1Valid_d};

    if (inflight_q) begin
      if (!slot0Valid_d) begin
        slot0Valid_d = 1'b1;
        slot0Data_d  = buf_data;
      end else begin
        slot1Valid_d = 1'b1;
        slot1Data_d  = buf_data;
      end
    end

    if (flush) begin
      slot0Valid_d = 1'b0;
      slot1Valid_d = 1'b0;
      slot0Data_d  = '0;
      slot1Data_d  = '0;
      inflight_d   = 1'b0;
    end
  end

  // Slot and in-flight registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0Valid_q <= 1'b0;
      slot1Valid_q <= 1'b0;
      slot0Data_q  <= '0;
      slot1Data_q  <= '0;
      inflight_q   <= 1'b0;
    end else begin
      slot0Valid_q <= slot0Valid_d;
      slot1Valid_q <= slot1Valid_d;
      slot0Data_q  <= slot0Data_d;
      slot1Data_q  <= slot1Data_d;
      inflight_q   <= inflight_d;
    end
  end

  assign m_valid     = slot0Valid_q;
  assign m_data      = slot0Data_q;
  assign free_slots  = freeSlots;
  assign rd_inflight = inflight_q;

endmodule

// File: rtl/buffer_ctrl.sv
// Ring-FIFO sequencer for the 16 x 8-bit signed CNN scratch buffer.
// Drives the buffer's write port and read address, and hides its one-cycle
// read latency behind buf_ctrl_outstage so both sides stream 1 word/cycle.
// Define BUF_CTRL_ALMOST_FULL_EN to add parameter AF_THRESH and a registered
// almost_full output.
module buffer_ctrl
  import cnn_buf_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int AW    = BUF_AW,
  parameter int DW    = BUF_DW
`ifdef BUF_CTRL_ALMOST_FULL_EN
  , parameter int AF_THRESH = 12
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_valid,
  input  logic signed [DW-1:0] s_data,
  output logic                 s_ready,
  output logic                 m_valid,
  output logic signed [DW-1:0] m_data,
  input  logic                 m_ready,
  output logic                 wrb,
  output logic [AW-1:0]        wrb_addr,
  output logic signed [DW-1:0] wrb_data,
  output logic [AW-1:0]        rdb_addr,
  input  logic signed [DW-1:0] buf_data_out,
  output logic [AW:0]          count,
  input  logic                 flush
`ifdef BUF_CTRL_ALMOST_FULL_EN
  , output logic               almost_full
`endif
);

  localparam logic [AW:0] DepthC = (AW+1)'(DEPTH);

  logic [1:0]    rstSync_q;
  logic          rstSyncN;
  logic [AW-1:0] wrPtr_q,   wrPtr_d;
  logic [AW-1:0] rdPtr_q,   rdPtr_d;
  logic [AW-1:0] rdbAddr_q, rdbAddr_d;
  logic [AW:0]   count_q,   count_d;
  buf_ctrl_st_e  st_q;
  logic          accept;
  logic          issue;
  logic [1:0]    freeSlots;
  logic          rdInflight;

  // Reset asserts asynchronously but releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstSyncN = rstSync_q[1];

  // Handshakes: no write while full or flushing; a read is issued only when
  // there is a resident word and a slot left for it beyond the one in flight.
  always_comb begin
    s_ready = rstSyncN & (count_q < DepthC) & ~flush;
    accept  = s_valid & s_ready;
    issue   = rstSyncN & ~flush & (count_q != '0) & (freeSlots > {1'b0, rdInflight});
  end

  // Next-state for pointers, occupancy and the held read address.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    rdbAddr_d = rdbAddr_q;

    if (accept) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (issue) begin
      rdPtr_d   = rdPtr_q + 1'b1;
      rdbAddr_d = rdPtr_q;
    end

    case ({accept, issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end
  end

  // Pointer, occupancy and read-address registers.
  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      rdbAddr_q <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      rdbAddr_q <= rdbAddr_d;
    end
  end

  // Control state: a flush parks us in FLUSH for exactly one cycle.
  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) begin
      st_q <= RUN;
    end else begin
      case (st_q)
        RUN:     st_q <= flush ? FLUSH : RUN;
        FLUSH:   st_q <= RUN;
        default: st_q <= RUN;
      endcase
    end
  end

`ifdef BUF_CTRL_ALMOST_FULL_EN
  localparam logic [AW:0] AfThreshC = (AW+1)'(AF_THRESH);
  logic almostFull_q;

  // Registered from next-state occupancy so it lines up with count.
  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) begin
      almostFull_q <= 1'b0;
    end else begin
      almostFull_q <= (count_d >= AfThreshC);
    end
  end

  assign almost_full = almostFull_q;
`endif

  buf_ctrl_outstage #(
    .DW (DW)
  ) u_outstage (
    .clk         (clk),
    .rst_n       (rstSyncN),
    .flush       (flush),
    .issue       (issue),
    .buf_data    (buf_data_out),
    .m_ready     (m_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .free_slots  (freeSlots),
    .rd_inflight (rdInflight)
  );

  assign wrb      = accept;
  assign wrb_addr = wrPtr_q;
  assign wrb_data = accept ? s_data : '0;
  assign rdb_addr = rdbAddr_d;
  assign count    = count_q;

endmodule
